// File: rtl/edf_sched_pkg.sv
// edf_sched_pkg: shared state encoding and wrap-around deadline helpers for EDF blocks
package edf_sched_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PICK   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  // a is earlier than b when (a - b) mod 2^w has its top bit set; valid for w <= 32
  function automatic logic earlier(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] d;
    logic [4:0]  s;
    d = a - b;
    s = w[4:0] - 5'd1;
    return d[s];
  endfunction

  // a deadline is expired when it lies strictly before the current time
  function automatic logic expired(input logic [31:0] d, input logic [31:0] t, input int w);
    return earlier(d, t, w);
  endfunction

endpackage

// File: rtl/edf_min_tree.sv
// edf_min_tree: combinational tournament picking the earliest valid head, ties to lower index
module edf_min_tree
  import edf_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = DW_DEF
) (
  input  logic [N-1:0]         q_valid,
  input  logic [N*DW-1:0]      q_head,
  output logic                 any_valid,
  output logic [$clog2(N)-1:0] min_idx,
  output logic [DW-1:0]        min_data
);

  localparam int IW = $clog2(N);
  localparam int P  = 1 << IW;

  // heap layout: node k has children 2k and 2k+1, leaves live at P..2P-1
  logic          w_v [1:2*P-1];
  logic [DW-1:0] w_d [1:2*P-1];
  logic [IW-1:0] w_i [1:2*P-1];

  for (genvar l = 0; l < P; l++) begin : g_leaf
    if (l < N) begin : g_real
      assign w_v[P+l] = q_valid[l];
      assign w_d[P+l] = q_valid[l] ? q_head[l*DW +: DW] : '0;
    end else begin : g_pad
      assign w_v[P+l] = 1'b0;
      assign w_d[P+l] = '0;
    end
    assign w_i[P+l] = IW'(l);
  end

  // right child wins only if strictly earlier, so equal deadlines keep the lower index
  for (genvar k = 1; k < P; k++) begin : g_node
    logic w_r;
    assign w_r    = w_v[2*k+1] && (!w_v[2*k] || earlier(32'(w_d[2*k+1]), 32'(w_d[2*k]), DW));
    assign w_v[k] = w_v[2*k] | w_v[2*k+1];
    assign w_d[k] = w_r ? w_d[2*k+1] : w_d[2*k];
    assign w_i[k] = w_r ? w_i[2*k+1] : w_i[2*k];
  end

  assign any_valid = w_v[1];
  assign min_idx   = w_i[1];
  assign min_data  = w_d[1];

endmodule

// File: rtl/edf_sched.sv
// edf_sched: earliest-deadline-first scheduler popping N prio_fifo heads onto a valid/ready egress
module edf_sched
  import edf_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = DW_DEF,
  parameter int SETTLE  = 2,
  parameter int DROP_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         q_valid,
  input  logic [N*DW-1:0]      q_head,
  output logic [N-1:0]         q_re,
  input  logic [DW-1:0]        now,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_port,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;

  state_t        r_state, w_next, w_after;
  logic          w_any, w_drop;
  logic [IW-1:0] w_min_idx;
  logic [DW-1:0] w_min_data;
  logic [IW-1:0] r_win_idx;
  logic [DW-1:0] r_win_data;
  logic          r_win_exp;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [IW-1:0] r_out_port;
  logic [15:0]   r_drop_cnt;
  logic [CW-1:0] r_cnt;

  edf_min_tree #(.N(N), .DW(DW)) u_tree (
    .q_valid  (q_valid),
    .q_head   (q_head),
    .any_valid(w_any),
    .min_idx  (w_min_idx),
    .min_data (w_min_data)
  );

  assign w_drop  = (DROP_EN != 0) && r_win_exp;
  assign w_after = (SETTLE == 0) ? ST_IDLE : ST_SETTLE;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next-state decode; HOLD only exits on the handshake, SETTLE after SETTLE cycles
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = |q_valid ? ST_PICK : ST_IDLE;
      ST_PICK:   w_next = w_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  w_next = w_drop ? w_after : ST_HOLD;
      ST_HOLD:   w_next = out_ready ? w_after : ST_HOLD;
      ST_SETTLE: w_next = (r_cnt == CW'(SETTLE - 1)) ? ST_IDLE : ST_SETTLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // winner capture, egress registers, drop counter and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_idx   <= '0;
      r_win_data  <= '0;
      r_win_exp   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_drop_cnt  <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_state == ST_PICK && w_any) begin
        r_win_idx  <= w_min_idx;
        r_win_data <= w_min_data;
        r_win_exp  <= expired(32'(w_min_data), 32'(now), DW);
      end
      if (r_state == ST_ISSUE && w_drop)
        r_drop_cnt <= (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + 16'd1;
      if (r_state == ST_ISSUE && !w_drop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_win_data;
        r_out_port  <= r_win_idx;
      end
      if (r_state == ST_HOLD && out_ready)
        r_out_valid <= 1'b0;
      r_cnt <= (r_state == ST_SETTLE) ? r_cnt + 1'b1 : '0;
    end
  end

  assign q_re      = (r_state == ST_ISSUE) ? N'(1) << r_win_idx : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_port  = r_out_port;
  assign drop_cnt  = r_drop_cnt;
  assign busy      = r_state != ST_IDLE;

endmodule

// File: tb/tb_edf_sched.sv
// tb_edf_sched: table-driven and sequence checks of edf_sched against a scoreboard of expected transfers
module tb_edf_sched;

  typedef struct {
    logic [1:0]  port;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] h;
    logic [3:0]  v;
    logic [15:0] now;
    logic        de;
    int          ne;
    logic [7:0]  ep;
    logic [63:0] ed;
    int          drops;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] now = '0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  w_qv, qv1, qv0, re1, re0, re_sel;
  logic [63:0] w_qh;
  logic        ov1, ov0, b1, b0;
  logic [15:0] od1, od0, dc1, dc0;
  logic [1:0]  op1, op0;
  logic        cur_ov, cur_b;
  logic [15:0] cur_od, cur_dc;
  logic [1:0]  cur_op;
  logic [15:0] qm [4][32];
  int          qn [4];
  int          pops [4];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  int          exp_drop1 = 0;
  vec_t        tv [8];

  edf_sched #(.N(4), .DW(16), .SETTLE(2), .DROP_EN(1)) dut (
    .clk(clk), .rst(rst), .q_valid(qv1), .q_head(w_qh), .q_re(re1), .now(now),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_port(op1),
    .drop_cnt(dc1), .busy(b1)
  );

  edf_sched #(.N(4), .DW(16), .SETTLE(2), .DROP_EN(0)) dut0 (
    .clk(clk), .rst(rst), .q_valid(qv0), .q_head(w_qh), .q_re(re0), .now(now),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_port(op0),
    .drop_cnt(dc0), .busy(b0)
  );

  always #5 clk = ~clk;

  assign qv1    = sel ? 4'b0 : w_qv;
  assign qv0    = sel ? w_qv : 4'b0;
  assign re_sel = sel ? re0 : re1;
  assign cur_ov = sel ? ov0 : ov1;
  assign cur_od = sel ? od0 : od1;
  assign cur_op = sel ? op0 : op1;
  assign cur_dc = sel ? dc0 : dc1;
  assign cur_b  = sel ? b0 : b1;

  // queue model: each prio_fifo shows its next stored word until popped
  always_comb begin
    w_qv = '0;
    w_qh = '0;
    for (int i = 0; i < 4; i++) begin
      w_qv[i] = pops[i] < qn[i];
      w_qh[i*16 +: 16] = (pops[i] < qn[i]) ? qm[i][pops[i]] : 16'h0;
    end
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (re_sel[i]) pops[i] <= pops[i] + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [15:0] d);
    qm[i][qn[i]] = d;
    qn[i] = qn[i] + 1;
  endtask

  task automatic wait_ov(input string name);
    int n;
    n = 0;
    while (!cur_ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " out_valid timeout"}, 32'(n < 20), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((w_qv != 4'b0 || cur_b) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, " drain timeout"}, 32'(n < 300), 32'd1);
    @(posedge clk);
    #1;
    chk({name, " leftover expected"}, 32'(sb.size()), 32'd0);
  endtask

  // scoreboard consumer and one-hot pop monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      tests++;
      if (!$onehot0(re_sel)) begin
        fails++;
        $display("FAIL q_re onehot: got %b required at most one bit", re_sel);
      end
      if (cur_ov && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected transfer: got port %0d data %h required none", cur_op, cur_od);
        end else begin
          e = sb.pop_front();
          chk("xfer port", 32'(cur_op), 32'(e.port));
          chk("xfer data", 32'(cur_od), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{64'h0000_0000_0050_0000, 4'b0010, 16'h0010, 1'b1, 1, 8'b00_00_00_01, 64'h0000_0000_0000_0050, 0};
    tv[1] = '{64'h0040_0020_0020_0030, 4'b1111, 16'h0010, 1'b1, 4, 8'b11_00_10_01, 64'h0040_0030_0020_0020, 0};
    tv[2] = '{64'h0000_0000_0004_FFF8, 4'b0011, 16'hFFF0, 1'b1, 2, 8'b00_00_01_00, 64'h0000_0000_0004_FFF8, 0};
    tv[3] = '{64'h0000_0000_0120_00F0, 4'b0011, 16'h0100, 1'b1, 1, 8'b00_00_00_01, 64'h0000_0000_0000_0120, 1};
    tv[4] = '{64'h0000_0000_0120_00F0, 4'b0011, 16'h0100, 1'b0, 2, 8'b00_00_01_00, 64'h0000_0000_0120_00F0, 0};
    tv[5] = '{64'h0200_01FF_0000_0000, 4'b1100, 16'h0200, 1'b1, 1, 8'b00_00_00_11, 64'h0000_0000_0000_0200, 1};
    tv[6] = '{64'h0500_0500_0500_0500, 4'b1111, 16'h0400, 1'b0, 4, 8'b11_10_01_00, 64'h0500_0500_0500_0500, 0};
    tv[7] = '{64'h0000_0000_8000_0000, 4'b0011, 16'h0000, 1'b0, 2, 8'b00_00_00_01, 64'h0000_0000_0000_8000, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset q_re", 32'(re1), 32'd0);
    chk("reset out_valid", 32'(ov1), 32'd0);
    chk("reset out_data", 32'(od1), 32'd0);
    chk("reset out_port", 32'(op1), 32'd0);
    chk("reset drop_cnt", 32'(dc1), 32'd0);
    chk("reset busy", 32'(b1), 32'd0);

    // single-queue latency: valid in t, PICK t+1, q_re t+2, out_valid t+3, SETTLE t+4..t+5
    @(posedge clk);
    #1;
    now = 16'h0010;
    load(1, 16'h0050);
    sb.push_back('{2'd1, 16'h0050});
    @(negedge clk);
    chk("t busy", 32'(b1), 32'd0);
    chk("t q_re", 32'(re1), 32'd0);
    @(negedge clk);
    chk("t+1 busy", 32'(b1), 32'd1);
    chk("t+1 q_re", 32'(re1), 32'd0);
    @(negedge clk);
    chk("t+2 q_re", 32'(re1), 32'b0010);
    chk("t+2 out_valid", 32'(ov1), 32'd0);
    @(negedge clk);
    chk("t+3 out_valid", 32'(ov1), 32'd1);
    chk("t+3 out_data", 32'(od1), 32'h0050);
    chk("t+3 out_port", 32'(op1), 32'd1);
    @(negedge clk);
    chk("t+4 out_valid", 32'(ov1), 32'd0);
    chk("t+4 busy", 32'(b1), 32'd1);
    @(negedge clk);
    chk("t+5 busy", 32'(b1), 32'd1);
    @(negedge clk);
    chk("t+6 busy", 32'(b1), 32'd0);
    chk("t drop_cnt", 32'(dc1), 32'd0);

    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      sel = !tv[j].de;
      now = tv[j].now;
      for (int i = 0; i < 4; i++)
        if (tv[j].v[i]) load(i, tv[j].h[i*16 +: 16]);
      for (int k = 0; k < tv[j].ne; k++)
        sb.push_back('{tv[j].ep[k*2 +: 2], tv[j].ed[k*16 +: 16]});
      if (tv[j].de) exp_drop1 += tv[j].drops;
      drain($sformatf("vec%0d", j));
      chk($sformatf("vec%0d drop_cnt", j), 32'(cur_dc), tv[j].de ? 32'(exp_drop1) : 32'd0);
    end

    // backpressure: word and port stay put and no further pops while out_ready is low
    @(posedge clk);
    #1;
    sel = 1'b0;
    now = 16'h0000;
    out_ready = 1'b0;
    load(0, 16'h0123);
    sb.push_back('{2'd0, 16'h0123});
    wait_ov("bp");
    for (int c = 0; c < 10; c++) begin
      chk("bp out_valid", 32'(ov1), 32'd1);
      chk("bp out_data", 32'(od1), 32'h0123);
      chk("bp out_port", 32'(op1), 32'd0);
      chk("bp q_re", 32'(re1), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp hs out_valid", 32'(ov1), 32'd1);
    @(negedge clk);
    chk("bp settle1 out_valid", 32'(ov1), 32'd0);
    chk("bp settle1 busy", 32'(b1), 32'd1);
    @(negedge clk);
    chk("bp settle2 busy", 32'(b1), 32'd1);
    @(negedge clk);
    chk("bp idle busy", 32'(b1), 32'd0);

    // reset in HOLD: held word is lost, everything back to reset values, then normal service
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    load(2, 16'h0777);
    wait_ov("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_drop1 = 0;
    @(negedge clk);
    chk("rst out_valid", 32'(ov1), 32'd0);
    chk("rst q_re", 32'(re1), 32'd0);
    chk("rst busy", 32'(b1), 32'd0);
    chk("rst drop_cnt", 32'(dc1), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    load(3, 16'h0888);
    sb.push_back('{2'd3, 16'h0888});
    drain("post-rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
